car_sensor_conditioner: RTL
===========================

# car_sensor_conditioner

Conditions the raw roadside loop-detector signal into the clean `CARS` request consumed by the traffic light controller, sitting directly upstream of it. Synchronizes the asynchronous sensor, debounces vehicle arrival and departure with a four-state FSM, latches a service request until the local road has been given green and cleared, and keeps a saturating vehicle tally for diagnostics.

## Interface
- `DEBOUNCE_CYCLES`, default 4: consecutive synchronized-high samples required to qualify arrival; legal range ≥ 2.
- `HOLD_CYCLES`, default 16: consecutive synchronized-low samples required to declare departure; legal range ≥ 2.
- `COUNT_WIDTH`, default 8: width of the vehicle tally.
- `clk`, input, 1: sole clock; all state updates on the rising edge.
- `reset`, input, 1: synchronous, active-high; clears all state.
- `SENSOR_RAW`, input, 1: raw loop detector, asynchronous to `clk`, noisy.
- `LOCAL_GREEN`, input, 1: local green lamp from the controller; indicates the request is being served.
- `COUNT_CLEAR`, input, 1: synchronous clear of `VEHICLE_COUNT`.
- `CARS`, output, 1: latched service request to the controller.
- `VEHICLE_PRESENT`, output, 1: debounced presence (state PRESENT or RELEASE).
- `VEHICLE_COUNT`, output, `COUNT_WIDTH`: qualified arrivals, saturating.

## Operation
- Synchronizer: two flops `s1 <= SENSOR_RAW`, `s2 <= s1`; the FSM uses only `s2`.
- Internal counter `dbc`, width `$clog2(max(DEBOUNCE_CYCLES,HOLD_CYCLES))+1`, reused by QUALIFY and RELEASE.
- FSM states and transitions:
  - IDLE: `s2=1` → QUALIFY, `dbc<=1`. Otherwise stay.
  - QUALIFY: `s2=0` → IDLE. `s2=1` and `dbc==DEBOUNCE_CYCLES-1` → PRESENT (arrival event). Otherwise `dbc++`.
  - PRESENT: `s2=0` → RELEASE, `dbc<=1`. Otherwise stay.
  - RELEASE: `s2=1` → PRESENT; this is not a new arrival, so there is no count and no set. `s2=0` and `dbc==HOLD_CYCLES-1` → IDLE. Otherwise `dbc++`.
- Arrival event (QUALIFY→PRESENT):
  - sets `CARS`.
  - increments `VEHICLE_COUNT` unless it is already all-ones (saturates, no wrap).
- `CARS` clear: `CARS<=0` when `LOCAL_GREEN=1` and state is IDLE. Set and clear are mutually exclusive by construction.
- `CARS` persistence:
  - `CARS` stays set while the vehicle remains, even under green.
  - `CARS` stays set after departure until green is seen.
- `COUNT_CLEAR`:
  - zeroes the count.
  - If it coincides with an arrival event, the count becomes 1.
- `VEHICLE_PRESENT` is a decode of the state register (PRESENT or RELEASE), so it is glitch-free.

## Timing
- Reset values: `CARS=0`, `VEHICLE_PRESENT=0`, `VEHICLE_COUNT=0`, state IDLE, `dbc=0`, `s1=s2=0`. Reset asserted mid-qualify or mid-hold abandons the operation; the first post-reset cycle is IDLE.
- Arrival latency: `SENSOR_RAW` is first sampled high at edge E0 and held high. `CARS` and `VEHICLE_PRESENT` rise after edge E(DEBOUNCE_CYCLES+1), which is E5 at the default.
- Glitch rejection: a high pulse yielding fewer than DEBOUNCE_CYCLES high `s2` samples returns to IDLE with no output change.
- Departure latency: `SENSOR_RAW` is first sampled low at edge F0 and held low. `VEHICLE_PRESENT` falls after edge F(HOLD_CYCLES+1), which is F17 at the default.
- Dropout rejection: low dropouts shorter than HOLD_CYCLES `s2` samples keep `VEHICLE_PRESENT=1` and add no count.
- `CARS` clear latency: state is IDLE and `LOCAL_GREEN=1` in cycle N, so `CARS=0` from cycle N+1.
- `LOCAL_GREEN` is synchronous to `clk` (it comes from the controller); no synchronizer is applied to it.

## Test plan
- Reset, then hold `SENSOR_RAW=1` from edge 0 (defaults) → `CARS` and `VEHICLE_PRESENT` go 1 after edge 5; `VEHICLE_COUNT=1`.
- Raw high pulse of 3 cycles, then low → `CARS`, `VEHICLE_PRESENT` and `VEHICLE_COUNT` remain 0.
- Vehicle present, then raw low for 10 cycles, then high again → `VEHICLE_PRESENT` stays 1 throughout and `VEHICLE_COUNT` stays 1. Then raw low for 20 cycles → `VEHICLE_PRESENT` falls after the 17th edge from the first low sample.
- After departure with `CARS=1`, assert `LOCAL_GREEN=1` → `CARS=0` one cycle later. Then assert `LOCAL_GREEN=1` while a vehicle is present → `CARS` stays 1.
- 255 separate qualified arrivals at `COUNT_WIDTH=8`, then one more → count holds at 255. `COUNT_CLEAR` asserted on an arrival edge → count becomes 1.
- Assert `reset` during QUALIFY (dbc=2) and during RELEASE → all outputs 0 the next cycle; the next arrival needs the full 4-sample qualification.

Source files
------------

// File: rtl/car_sensor_conditioner.sv
// car_sensor_conditioner: synchronizes and debounces the loop detector, latches the CARS request
// until the local road is served, and keeps a saturating vehicle tally.
module car_sensor_conditioner #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int HOLD_CYCLES     = 16,
    parameter int COUNT_WIDTH     = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   SENSOR_RAW,
    input  logic                   LOCAL_GREEN,
    input  logic                   COUNT_CLEAR,
    output logic                   CARS,
    output logic                   VEHICLE_PRESENT,
    output logic [COUNT_WIDTH-1:0] VEHICLE_COUNT
);
    localparam int MAXC = DEBOUNCE_CYCLES > HOLD_CYCLES ? DEBOUNCE_CYCLES : HOLD_CYCLES;
    localparam int DW   = $clog2(MAXC) + 1;
    typedef enum logic [1:0] {IDLE, QUALIFY, PRESENT, RELEASE} state_t;
    state_t        state;
    logic          s1, s2;
    logic [DW-1:0] dbc;
    logic          arrival;
    assign arrival         = state == QUALIFY && s2 && dbc == DW'(DEBOUNCE_CYCLES - 1);
    assign VEHICLE_PRESENT = state == PRESENT || state == RELEASE;
    always_ff @(posedge clk) begin
        if (reset) begin
            s1            <= 1'b0;
            s2            <= 1'b0;
            state         <= IDLE;
            dbc           <= '0;
            CARS          <= 1'b0;
            VEHICLE_COUNT <= '0;
        end else begin
            s1 <= SENSOR_RAW;
            s2 <= s1;
            case (state)
                IDLE:
                    if (s2) begin
                        state <= QUALIFY;
                        dbc   <= DW'(1);
                    end
                QUALIFY:
                    if (!s2) state <= IDLE;
                    else if (arrival) state <= PRESENT;
                    else dbc <= dbc + DW'(1);
                PRESENT:
                    if (!s2) begin
                        state <= RELEASE;
                        dbc   <= DW'(1);
                    end
                RELEASE:
                    if (s2) state <= PRESENT;
                    else if (dbc == DW'(HOLD_CYCLES - 1)) state <= IDLE;
                    else dbc <= dbc + DW'(1);
                default: state <= IDLE;
            endcase
            // the request is only retired once the road is clear and has been served
            if (arrival) CARS <= 1'b1;
            else if (state == IDLE && LOCAL_GREEN) CARS <= 1'b0;
            if (COUNT_CLEAR) VEHICLE_COUNT <= arrival ? COUNT_WIDTH'(1) : '0;
            else if (arrival && !(&VEHICLE_COUNT)) VEHICLE_COUNT <= VEHICLE_COUNT + COUNT_WIDTH'(1);
        end
    end
endmodule
